// File: rtl/sr_ctf_pkg.sv
// Shared types and constants for the counterflow shift-register deserializer.
package sr_ctf_pkg;

    typedef enum logic {IDLE, ARMED} sr_ctf_state_t;

    localparam int unsigned SR_CTF_SYNC_STAGES = 2;

endpackage

// File: rtl/sr_ctf_pulse_sync.sv
// Multi-flop synchronizer plus rising-edge detector; emits a one-cycle strobe per input pulse.
module sr_ctf_pulse_sync
    import sr_ctf_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic strobe_o
);

    // Top bit holds the previous synchronized level for edge detection.
    logic [SR_CTF_SYNC_STAGES:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SR_CTF_SYNC_STAGES-1:0], async_i};
        end
    end

    assign strobe_o = sync_q[SR_CTF_SYNC_STAGES-1] & ~sync_q[SR_CTF_SYNC_STAGES];

endmodule

// File: rtl/sr_ctf_deser.sv
// Pairs dout/cout pulses from the chain end into bits and delivers words over valid/ready.
// Optional parity frame bit enabled with `define SR_CTF_DESER_PARITY_EN.
module sr_ctf_deser
    import sr_ctf_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned WINDOW = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dout_in,
    input  logic             cout_in,
    output logic [WIDTH-1:0] word,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             perr,
    output logic             pair_err,
    output logic             overrun
);

`ifdef SR_CTF_DESER_PARITY_EN
    localparam int unsigned FRAME = WIDTH + 1;
`else
    localparam int unsigned FRAME = WIDTH;
`endif
    localparam int unsigned BCW = $clog2(FRAME);

    sr_ctf_state_t    state_q;
    logic [7:0]       win_q;
    logic [BCW-1:0]   bit_cnt_q;
    logic [FRAME-1:0] shreg_q;
    logic [WIDTH-1:0] word_q;
    logic             valid_q;
    logic             perr_q;
    logic             pair_err_q;
    logic             overrun_q;

    logic             d_ev;
    logic             c_ev;
    logic             bit_val;
    logic [FRAME-1:0] frame;
    logic             frame_perr;
    logic             last_bit;
    logic             accept;
    logic             load;

    sr_ctf_pulse_sync u_dout_sync (
        .clk_i    (clk),
        .rst_i    (rst),
        .async_i  (dout_in),
        .strobe_o (d_ev)
    );

    sr_ctf_pulse_sync u_cout_sync (
        .clk_i    (clk),
        .rst_i    (rst),
        .async_i  (cout_in),
        .strobe_o (c_ev)
    );

    // A cout closes the slot; the bit is '1' if a dout is pending or arrives together.
    assign bit_val  = d_ev | (state_q == ARMED);
    assign frame    = {bit_val, shreg_q[FRAME-1:1]};
    assign last_bit = c_ev && (bit_cnt_q == BCW'(FRAME - 1));
    assign accept   = valid_q & word_ready;
    assign load     = last_bit & (~valid_q | accept);

`ifdef SR_CTF_DESER_PARITY_EN
    assign frame_perr = ^frame;
`else
    assign frame_perr = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            win_q      <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            word_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            pair_err_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            pair_err_q <= 1'b0;
            if (c_ev) begin
                state_q <= IDLE;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (d_ev) begin
                            state_q <= ARMED;
                            win_q   <= '0;
                        end
                    end
                    ARMED: begin
                        if (win_q == 8'(WINDOW - 1)) begin
                            pair_err_q <= 1'b1;
                            state_q    <= IDLE;
                        end else begin
                            win_q <= win_q + 8'd1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end

            if (c_ev) begin
                shreg_q   <= frame;
                bit_cnt_q <= last_bit ? '0 : bit_cnt_q + 1'b1;
            end

            if (accept) begin
                valid_q <= 1'b0;
            end
            if (load) begin
                valid_q <= 1'b1;
                word_q  <= frame[WIDTH-1:0];
                perr_q  <= frame_perr;
            end else if (last_bit) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign word       = word_q;
    assign word_valid = valid_q;
    assign perr       = perr_q;
    assign pair_err   = pair_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_sr_ctf_deser.sv
// Self-checking bench for sr_ctf_deser: directed scenarios plus random frames against a word-level model.
module tb_sr_ctf_deser;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned WINDOW = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             dout_in;
    logic             cout_in;
    logic [WIDTH-1:0] word;
    logic             word_valid;
    logic             word_ready;
    logic             perr;
    logic             pair_err;
    logic             overrun;

    int n_checks = 0;
    int n_err    = 0;

    int             cyc      = 0;
    int             vcnt     = 0;
    int             cap_cnt  = 0;
    logic [WIDTH-1:0] cap_word = '0;
    logic           cap_perr = 1'b0;
    int             pair_cnt = 0;
    int             pair_cyc = 0;

    sr_ctf_deser #(
        .WIDTH  (WIDTH),
        .WINDOW (WINDOW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dout_in    (dout_in),
        .cout_in    (cout_in),
        .word       (word),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .perr       (perr),
        .pair_err   (pair_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (word_valid) vcnt <= vcnt + 1;
        if (word_valid && word_ready) begin
            cap_cnt  <= cap_cnt + 1;
            cap_word <= word;
            cap_perr <= perr;
        end
        if (pair_err) begin
            pair_cnt <= pair_cnt + 1;
            pair_cyc <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // dout (if '1') rises 4 clk ahead of cout, or together with it when simul is set.
    task automatic send_bit(input logic b, input bit simul);
        @(negedge clk);
        if (b && simul) begin
            dout_in = 1'b1;
            cout_in = 1'b1;
            repeat (2) @(negedge clk);
            dout_in = 1'b0;
            cout_in = 1'b0;
        end else begin
            if (b) dout_in = 1'b1;
            repeat (2) @(negedge clk);
            dout_in = 1'b0;
            repeat (2) @(negedge clk);
            cout_in = 1'b1;
            repeat (2) @(negedge clk);
            cout_in = 1'b0;
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic send_bits(input logic [WIDTH-1:0] data, input int lo, input int hi,
                             input bit simul);
        for (int i = lo; i <= hi; i++) send_bit(data[i], simul);
    endtask

    task automatic send_tail(input logic [WIDTH-1:0] data, input bit simul);
`ifdef SR_CTF_DESER_PARITY_EN
        send_bit(^data, simul);
`else
        if (simul && data[0] === 1'bx) send_bit(1'b0, 1'b0);
`endif
    endtask

    task automatic send_word(input logic [WIDTH-1:0] data, input bit simul);
        send_bits(data, 0, WIDTH - 1, simul);
        send_tail(data, simul);
    endtask

    task automatic accept_word();
        @(negedge clk);
        word_ready = 1'b1;
        @(negedge clk);
        word_ready = 1'b0;
    endtask

    initial begin : main
        int v0, c0, p0, t0;
        logic [WIDTH-1:0] data;
        logic par;
        bit simul;
        logic exp_valid, exp_perr, exp_ovr;
        logic [WIDTH-1:0] exp_word;

        rst        = 1'b1;
        dout_in    = 1'b0;
        cout_in    = 1'b0;
        word_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_word", 32'(word), 32'h0);
        chk("rst_valid", 32'(word_valid), 32'h0);
        chk("rst_perr", 32'(perr), 32'h0);
        chk("rst_pair_err", 32'(pair_err), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);

        // Word 8'h8D (bits 1,0,1,1,0,0,0,1) with ready held high.
        v0 = vcnt; c0 = cap_cnt; p0 = pair_cnt;
        word_ready = 1'b1;
        send_word(8'h8D, 1'b0);
        word_ready = 1'b0;
        chk("t1_accepts", 32'(cap_cnt - c0), 32'd1);
        chk("t1_word", 32'(cap_word), 32'h8D);
        chk("t1_valid_cycles", 32'(vcnt - v0), 32'd1);
        chk("t1_perr", 32'(cap_perr), 32'h0);
        chk("t1_pair_err", 32'(pair_cnt - p0), 32'd0);
        chk("t1_overrun", 32'(overrun), 32'h0);

        // Two words with ready low: first held, second dropped.
        send_word(8'h8D, 1'b0);
        send_word(8'h5A, 1'b0);
        chk("ovr_valid", 32'(word_valid), 32'h1);
        chk("ovr_word", 32'(word), 32'h8D);
        chk("ovr_flag", 32'(overrun), 32'h1);
        accept_word();
        chk("ovr_valid_cleared", 32'(word_valid), 32'h0);
        chk("ovr_sticky", 32'(overrun), 32'h1);
        do_reset();
        chk("ovr_cleared_by_rst", 32'(overrun), 32'h0);

        // Lone dout mid-frame: one pair_err, bit count unaffected.
        send_bits(8'hAB, 0, 2, 1'b0);
        p0 = pair_cnt;
        @(negedge clk);
        t0 = cyc;
        dout_in = 1'b1;
        repeat (2) @(negedge clk);
        dout_in = 1'b0;
        repeat (12) @(negedge clk);
        chk("pe_count", 32'(pair_cnt - p0), 32'd1);
        chk("pe_delay_ok", 32'((pair_cyc - t0) >= 8 && (pair_cyc - t0) <= 10), 32'd1);
        send_bits(8'hAB, 3, WIDTH - 1, 1'b0);
        send_tail(8'hAB, 1'b0);
        chk("pe_word", 32'(word), 32'hAB);
        chk("pe_valid", 32'(word_valid), 32'h1);
        accept_word();

        // Coincident dout/cout pulses record '1' without pair_err.
        p0 = pair_cnt;
        send_word(8'hC5, 1'b1);
        chk("sim_word", 32'(word), 32'hC5);
        chk("sim_pair_err", 32'(pair_cnt - p0), 32'd0);
        accept_word();

        // Reset after 5 bits discards them.
        send_bits(8'h12, 0, 4, 1'b0);
        do_reset();
        send_word(8'hFF, 1'b0);
        chk("rstmid_word", 32'(word), 32'hFF);
        chk("rstmid_valid", 32'(word_valid), 32'h1);
        accept_word();

`ifdef SR_CTF_DESER_PARITY_EN
        send_bits(8'h03, 0, WIDTH - 1, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("par1_word", 32'(word), 32'h03);
        chk("par1_perr", 32'(perr), 32'h1);
        accept_word();
        send_bits(8'h03, 0, WIDTH - 1, 1'b0);
        send_bit(1'b0, 1'b0);
        chk("par0_word", 32'(word), 32'h03);
        chk("par0_perr", 32'(perr), 32'h0);
        accept_word();
`endif

        // Random frames against a holding-register model.
        do_reset();
        exp_valid = 1'b0; exp_perr = 1'b0; exp_ovr = 1'b0; exp_word = '0;
        for (int f = 0; f < 12; f++) begin
            data  = WIDTH'($urandom);
            simul = bit'($urandom_range(0, 1));
            par   = 1'b0;
            send_bits(data, 0, WIDTH - 1, simul);
`ifdef SR_CTF_DESER_PARITY_EN
            par = (^data) ^ ($urandom_range(0, 3) == 0);
            send_bit(par, simul);
`endif
            if (exp_valid) begin
                exp_ovr = 1'b1;
            end else begin
                exp_valid = 1'b1;
                exp_word  = data;
`ifdef SR_CTF_DESER_PARITY_EN
                exp_perr = ^{par, data};
`else
                exp_perr = 1'b0;
`endif
            end
            chk("rnd_valid", 32'(word_valid), 32'(exp_valid));
            chk("rnd_word", 32'(word), 32'(exp_word));
            chk("rnd_perr", 32'(perr), 32'(exp_perr));
            chk("rnd_overrun", 32'(overrun), 32'(exp_ovr));
            if ($urandom_range(0, 2) != 0) begin
                accept_word();
                exp_valid = 1'b0;
                chk("rnd_accept", 32'(word_valid), 32'(exp_valid));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
